// File: rtl/key_cfg_ctrl.sv
// key_cfg_ctrl: turns debounced key pulses into OV7670 setting-register writes.
// Holds three 8-bit settings, steps the selected one with inc/dec, and can
// restore all three to their defaults with a three-write burst to the SCCB master.
`timescale 1ns/1ps
module key_cfg_ctrl #(
    parameter int unsigned KEY_W = 4,
    parameter logic [7:0]  ADDR0 = 8'h55,
    parameter logic [7:0]  ADDR1 = 8'h56,
    parameter logic [7:0]  ADDR2 = 8'h3F,
    parameter logic [7:0]  DEF0  = 8'h00,
    parameter logic [7:0]  DEF1  = 8'h40,
    parameter logic [7:0]  DEF2  = 8'h00,
    parameter logic [7:0]  STEP  = 8'h10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_vld,
    output logic             wr_req,
    output logic [7:0]       wr_addr,
    output logic [7:0]       wr_data,
    input  logic             wr_rdy,
    output logic             busy,
    output logic [1:0]       sel,
    output logic [7:0]       cur_val
);

    typedef enum logic [1:0] {StIdle, StWr, StRstWr} state_e;

    state_e     r_state, w_state_nxt;
    logic [1:0] r_sel, w_sel_nxt;
    logic [7:0] r_set0, r_set1, r_set2;
    logic [7:0] w_set0_nxt, w_set1_nxt, w_set2_nxt;
    logic       r_wr_req, w_wr_req_nxt;
    logic [7:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0] r_wr_data, w_wr_data_nxt;
    logic [1:0] r_idx, w_idx_nxt;

    logic [7:0] w_cur;
    logic [7:0] w_cur_addr;
    logic [7:0] w_inc;
    logic [7:0] w_dec;
    logic [7:0] w_step_val;

    // Selected setting and its register address.
    always_comb begin
        w_cur      = r_set2;
        w_cur_addr = ADDR2;
        case (r_sel)
            2'd0:    begin w_cur = r_set0; w_cur_addr = ADDR0; end
            2'd1:    begin w_cur = r_set1; w_cur_addr = ADDR1; end
            default: begin w_cur = r_set2; w_cur_addr = ADDR2; end
        endcase
    end

    // Saturating step values; inc takes priority over dec.
    always_comb begin
        w_inc      = (w_cur > (8'hFF - STEP)) ? 8'hFF : (w_cur + STEP);
        w_dec      = (w_cur < STEP) ? 8'h00 : (w_cur - STEP);
        w_step_val = key_vld[1] ? w_inc : w_dec;
    end

    // Next-state logic: key decode in idle, handshake tracking while busy.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_set0_nxt    = r_set0;
        w_set1_nxt    = r_set1;
        w_set2_nxt    = r_set2;
        w_wr_req_nxt  = r_wr_req;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_idx_nxt     = r_idx;
        unique case (r_state)
            StIdle: begin
                if (key_vld[3]) begin
                    w_set0_nxt    = DEF0;
                    w_set1_nxt    = DEF1;
                    w_set2_nxt    = DEF2;
                    w_sel_nxt     = 2'd0;
                    w_idx_nxt     = 2'd0;
                    w_wr_req_nxt  = 1'b1;
                    w_wr_addr_nxt = ADDR0;
                    w_wr_data_nxt = DEF0;
                    w_state_nxt   = StRstWr;
                end else if (key_vld[1] || key_vld[2]) begin
                    // A saturated setting produces no write at all.
                    if (w_step_val != w_cur) begin
                        case (r_sel)
                            2'd0:    w_set0_nxt = w_step_val;
                            2'd1:    w_set1_nxt = w_step_val;
                            default: w_set2_nxt = w_step_val;
                        endcase
                        w_wr_req_nxt  = 1'b1;
                        w_wr_addr_nxt = w_cur_addr;
                        w_wr_data_nxt = w_step_val;
                        w_state_nxt   = StWr;
                    end
                end else if (key_vld[0]) begin
                    w_sel_nxt = (r_sel == 2'd2) ? 2'd0 : (r_sel + 2'd1);
                end
            end
            StWr: begin
                if (wr_rdy) begin
                    w_wr_req_nxt = 1'b0;
                    w_state_nxt  = StIdle;
                end
            end
            StRstWr: begin
                if (r_wr_req) begin
                    if (wr_rdy) begin
                        w_wr_req_nxt = 1'b0;
                        if (r_idx == 2'd2) begin
                            w_state_nxt = StIdle;
                        end else begin
                            w_idx_nxt = r_idx + 2'd1;
                        end
                    end
                end else begin
                    // Gap cycle after an acceptance: present the next default.
                    w_wr_req_nxt = 1'b1;
                    case (r_idx)
                        2'd0:    begin w_wr_addr_nxt = ADDR0; w_wr_data_nxt = DEF0; end
                        2'd1:    begin w_wr_addr_nxt = ADDR1; w_wr_data_nxt = DEF1; end
                        default: begin w_wr_addr_nxt = ADDR2; w_wr_data_nxt = DEF2; end
                    endcase
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_sel     <= 2'd0;
            r_set0    <= DEF0;
            r_set1    <= DEF1;
            r_set2    <= DEF2;
            r_wr_req  <= 1'b0;
            r_wr_addr <= 8'h00;
            r_wr_data <= 8'h00;
            r_idx     <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_set0    <= w_set0_nxt;
            r_set1    <= w_set1_nxt;
            r_set2    <= w_set2_nxt;
            r_wr_req  <= w_wr_req_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_idx     <= w_idx_nxt;
        end
    end

    assign wr_req  = r_wr_req;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state != StIdle);
    assign sel     = r_sel;
    assign cur_val = w_cur;

endmodule
